// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation unit: LINEAR, BINARY, SIGMOID, TANH, RELU and LEAKY_RELU per lane.
// Optional lane-saturation counter (sat_count/sat_clear) when ACTIVATION_PIPE_SAT_COUNT_EN is defined.
module activation_pipe #(
  parameter int DATA_SIZE     = 16,
  parameter int SIZE          = 3,
  parameter int ACTIVATE_SIZE = 4,
  parameter int FRAC_BITS     = 8,
  parameter int LEAK_SHIFT    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_SIZE*SIZE-1:0] in_data,
  input  logic [ACTIVATE_SIZE-1:0]  act,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_SIZE*SIZE-1:0] out_data
`ifdef ACTIVATION_PIPE_SAT_COUNT_EN
  ,
  output logic [15:0]               sat_count,
  input  logic                      sat_clear
`endif
);

  localparam int DS  = DATA_SIZE;
  localparam int W   = DATA_SIZE + 2;
  localparam int ONE = 1 << FRAC_BITS;

  localparam logic [ACTIVATE_SIZE-1:0] ACT_BINARY  = ACTIVATE_SIZE'(1);
  localparam logic [ACTIVATE_SIZE-1:0] ACT_SIGMOID = ACTIVATE_SIZE'(2);
  localparam logic [ACTIVATE_SIZE-1:0] ACT_TANH    = ACTIVATE_SIZE'(3);
  localparam logic [ACTIVATE_SIZE-1:0] ACT_RELU    = ACTIVATE_SIZE'(4);
  localparam logic [ACTIVATE_SIZE-1:0] ACT_LEAKY   = ACTIVATE_SIZE'(5);

  localparam logic signed [DS-1:0] MAX_D = {1'b0, {(DS-1){1'b1}}};
  localparam logic signed [DS-1:0] MIN_D = {1'b1, {(DS-1){1'b0}}};
  localparam logic signed [W-1:0]  MAX_W = {2'b00, MAX_D};
  localparam logic signed [W-1:0]  MIN_W = {2'b11, MIN_D};

  // Sigmoid breakpoints (5.0, 2.375, 1.0) and offsets (0.84375, 0.625, 0.5), truncated
  localparam logic [DS-1:0]       T_SAT = DS'(5 * ONE);
  localparam logic [DS-1:0]       T_HI  = DS'((19 * ONE) / 8);
  localparam logic [DS-1:0]       T_MID = DS'(ONE);
  localparam logic signed [W-1:0] ONE_W = W'(ONE);
  localparam logic signed [W-1:0] C_HI  = W'((27 * ONE) / 32);
  localparam logic signed [W-1:0] C_MID = W'((5 * ONE) / 8);
  localparam logic signed [W-1:0] C_LO  = W'(ONE / 2);

  typedef struct packed {
    logic          neg;
    logic [1:0]    seg;
    logic [DS-1:0] mag;
  } pre_t;

  function automatic logic signed [DS-1:0] dbl_sat(input logic signed [DS-1:0] x);
    if (x[DS-1] ^ x[DS-2]) return x[DS-1] ? MIN_D : MAX_D;
    return x <<< 1;
  endfunction

  function automatic pre_t pre_lane(input logic signed [DS-1:0] x, input logic is_tanh);
    pre_t p;
    logic signed [DS-1:0] z;
    z = is_tanh ? dbl_sat(x) : x;
    p.neg = z[DS-1];
    p.mag = (z == MIN_D) ? MAX_D : (p.neg ? -z : z);
    if (p.mag >= T_SAT)      p.seg = 2'd3;
    else if (p.mag >= T_HI)  p.seg = 2'd2;
    else if (p.mag >= T_MID) p.seg = 2'd1;
    else                     p.seg = 2'd0;
    return p;
  endfunction

  function automatic logic signed [W-1:0] sigmoid(input pre_t p);
    logic signed [W-1:0] a;
    logic signed [W-1:0] r;
    a = {2'b00, p.mag};
    case (p.seg)
      2'd3:    r = ONE_W;
      2'd2:    r = (a >>> 5) + C_HI;
      2'd1:    r = (a >>> 3) + C_MID;
      default: r = (a >>> 2) + C_LO;
    endcase
    return p.neg ? ONE_W - r : r;
  endfunction

  function automatic logic signed [W-1:0] lane_y(input logic signed [DS-1:0] x,
                                                 input logic [ACTIVATE_SIZE-1:0] mode,
                                                 input pre_t p);
    logic signed [W-1:0] xw;
    logic signed [W-1:0] s;
    logic signed [W-1:0] y;
    xw = W'(x);
    s  = sigmoid(p);
    case (mode)
      ACT_BINARY:  y = p.neg ? '0 : ONE_W;
      ACT_SIGMOID: y = s;
      ACT_TANH:    y = (s <<< 1) - ONE_W;
      ACT_RELU:    y = p.neg ? '0 : xw;
      ACT_LEAKY:   y = p.neg ? (xw >>> LEAK_SHIFT) : xw;
      default:     y = xw;
    endcase
    return y;
  endfunction

  function automatic logic [DS-1:0] clamp(input logic signed [W-1:0] y);
    if (y > MAX_W) return MAX_D;
    if (y < MIN_W) return MIN_D;
    return y[DS-1:0];
  endfunction

  logic                     s1_valid;
  logic                     s2_valid;
  logic [ACTIVATE_SIZE-1:0] s1_act;
  logic [DS-1:0]            s1_x   [SIZE];
  pre_t                     s1_pre [SIZE];
  logic [DS*SIZE-1:0]       nxt_data;
  logic signed [W-1:0]      y_w    [SIZE];
  logic                     adv1;
  logic                     adv2;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_act   <= '0;
      for (int i = 0; i < SIZE; i++) begin
        s1_x[i]   <= '0;
        s1_pre[i] <= '0;
      end
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_act <= act;
        for (int i = 0; i < SIZE; i++) begin
          s1_x[i]   <= in_data[(SIZE-i)*DS-1 -: DS];
          s1_pre[i] <= pre_lane(in_data[(SIZE-i)*DS-1 -: DS], act == ACT_TANH);
        end
      end
    end
  end

  always_comb begin
    nxt_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      y_w[i] = lane_y(s1_x[i], s1_act, s1_pre[i]);
      nxt_data[(SIZE-i)*DS-1 -: DS] = clamp(y_w[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) out_data <= nxt_data;
    end
  end

`ifdef ACTIVATION_PIPE_SAT_COUNT_EN
  logic [SIZE-1:0] s1_tsat;
  logic [SIZE-1:0] clip_mask;
  logic [SIZE-1:0] s2_clip;
  logic [16:0]     clip_cnt;
  logic [16:0]     sat_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tsat <= '0;
    end else if (adv1 && in_valid) begin
      for (int i = 0; i < SIZE; i++)
        s1_tsat[i] <= (act == ACT_TANH) &&
                      (in_data[(SIZE-i)*DS-1] ^ in_data[(SIZE-i)*DS-2]);
    end
  end

  always_comb begin
    clip_mask = '0;
    for (int i = 0; i < SIZE; i++)
      clip_mask[i] = (y_w[i] > MAX_W) || (y_w[i] < MIN_W) || s1_tsat[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  s2_clip <= '0;
    else if (adv2 && s1_valid)   s2_clip <= clip_mask;
  end

  always_comb begin
    clip_cnt = '0;
    for (int i = 0; i < SIZE; i++) clip_cnt = clip_cnt + 17'(s2_clip[i]);
    sat_sum = {1'b0, sat_count} + clip_cnt;
  end

  // Sticks at 0xFFFF rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sat_count <= '0;
    else if (sat_clear)              sat_count <= '0;
    else if (out_valid && out_ready) sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif

endmodule
